// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory port plus decoder-side
// valid/ready handshake, redirect input and fetched-word outputs.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct75;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misaligned;
  logic [31:0] instret;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output instr_valid,
    input  instr_ready, PCSrc, PCTarget,
    output Instr, op, funct3, funct75,
    output PC, PCPlus4, misaligned, instret
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  instr_valid,
    output instr_ready, PCSrc, PCTarget,
    input  Instr, op, funct3, funct75,
    input  PC, PCPlus4, misaligned, instret
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, one outstanding imem request,
// registers the returned word and hands it to the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    VALID
  } state_t;

  state_t      state;
  state_t      nstate;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  logic [31:0] pc_plus4;
  logic        mis_q;
  logic        drop_q;
  logic        req;
  logic        vld;
  logic        hs;
  logic        take;

  assign pc_plus4 = pc_q + 32'd4;
  assign hs       = vld & bus.instr_ready;
  assign take     = (state == WAIT) & bus.imem_rvalid;

  // A reset landing in WAIT leaves a response in flight; keep waiting
  // for it so it can be discarded.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= (state == WAIT) ? WAIT : FETCH;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      FETCH: nstate = WAIT;
      WAIT:  if (bus.imem_rvalid)
               nstate = drop_q ? FETCH : VALID;
      VALID: if (hs) nstate = FETCH;
      default: nstate = FETCH;
    endcase
  end

  always_comb begin
    req = 1'b0;
    vld = 1'b0;
    unique case (state)
      FETCH: req = rst_n;
      VALID: vld = rst_n;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= 32'd0;
      mis_q     <= 1'b0;
      drop_q    <= (state == WAIT);
    end else begin
      mis_q <= hs & bus.PCSrc & (|bus.PCTarget[1:0]);
      if (take) begin
        if (drop_q)
          drop_q <= 1'b0;
        else
          instr_q <= bus.imem_rdata;
      end
      if (hs) begin
        instret_q <= instret_q + 32'd1;
        instr_q   <= NOP_INSTR;
        pc_q      <= bus.PCSrc ?
                     {bus.PCTarget[31:2], 2'b00} :
                     pc_plus4;
      end
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = vld;
  assign bus.Instr       = instr_q;
  assign bus.op          = instr_q[6:0];
  assign bus.funct3      = instr_q[14:12];
  assign bus.funct75     = instr_q[30];
  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.misaligned  = mis_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-configurable imem model
// and hand-computed expectations per scenario.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int cnt = 0;
  int rvcnt = 0;
  logic [31:0] pend = 32'd0;
  logic [31:0] raddr[$];
  int rcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h40B5_0533;
    return {a[19:0], 12'h0B3};
  endfunction

  // memory model: answers each request exactly lat cycles later
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem(pend);
          rvcnt++;
        end
      end
      if (bus.imem_req) begin
        cnt  = lat;
        pend = bus.imem_addr;
        raddr.push_back(bus.imem_addr);
        rcyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bus.instr_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check("valid_tmo", 32'(bus.instr_valid), 32'd1);
  endtask

  initial begin
    int n;
    int rv0;
    logic seen;
    logic [31:0] pc0;
    logic [31:0] in0;

    bus.instr_ready = 1'b1;
    bus.PCSrc       = 1'b0;
    bus.PCTarget    = 32'd0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_pc", bus.PC, 32'h100);
    check("rst_instr", bus.Instr, 32'h13);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_mis", 32'(bus.misaligned), 32'd0);
    check("rst_instret", bus.instret, 32'd0);

    // reset fetch, L=1
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, 32'h100);
    wait_valid(20, n);
    check("lat1_valid", 32'(n), 32'd2);
    check("i0_instr", bus.Instr, 32'h40B5_0533);
    check("i0_op", 32'(bus.op), 32'h33);
    check("i0_f3", 32'(bus.funct3), 32'd0);
    check("i0_f75", 32'(bus.funct75), 32'd1);
    check("i0_pc", bus.PC, 32'h100);
    check("i0_pc4", bus.PCPlus4, 32'h104);
    n = 0;
    while (bus.instret != 32'd3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("instret3", bus.instret, 32'd3);
    check("nreq3", 32'(raddr.size() >= 3), 32'd1);
    check("req0", raddr[0], 32'h100);
    check("req1", raddr[1], 32'h104);
    check("req2", raddr[2], 32'h108);
    check("gap01", 32'(rcyc[1] - rcyc[0]), 32'd3);
    check("gap12", 32'(rcyc[2] - rcyc[1]), 32'd3);

    // backpressure in VALID
    bus.instr_ready = 1'b0;
    wait_valid(20, n);
    check("bp_pc0", bus.PC, 32'h10C);
    pc0 = bus.PC;
    in0 = bus.Instr;
    check("bp_in0", in0, mem(32'h10C));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_pc", bus.PC, pc0);
      check("bp_instr", bus.Instr, in0);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_req", 32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("hs_valid", 32'(bus.instr_valid), 32'd0);
    check("hs_instret", bus.instret, 32'd4);
    check("hs_nop", bus.Instr, 32'h13);
    check("hs_req", 32'(bus.imem_req), 32'd1);
    check("hs_addr", bus.imem_addr, 32'h110);

    // redirect, aligned then misaligned
    bus.instr_ready = 1'b0;
    wait_valid(20, n);
    bus.PCSrc       = 1'b1;
    bus.PCTarget    = 32'h200;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("rd_req", 32'(bus.imem_req), 32'd1);
    check("rd_addr", bus.imem_addr, 32'h200);
    check("rd_mis", 32'(bus.misaligned), 32'd0);
    bus.instr_ready = 1'b0;
    wait_valid(20, n);
    check("rd_pc", bus.PC, 32'h200);
    bus.PCTarget    = 32'h302;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("mis_pulse", 32'(bus.misaligned), 32'd1);
    check("mis_addr", bus.imem_addr, 32'h300);
    @(negedge clk);
    check("mis_clear", 32'(bus.misaligned), 32'd0);

    // PC wrap through 0xFFFF_FFFC
    bus.instr_ready = 1'b0;
    wait_valid(20, n);
    bus.PCTarget    = 32'hFFFF_FFFC;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("wr_pc", bus.PC, 32'hFFFF_FFFC);
    check("wr_pc4", bus.PCPlus4, 32'd0);
    bus.PCSrc       = 1'b0;
    bus.instr_ready = 1'b0;
    wait_valid(20, n);
    check("wr_instr", bus.Instr, 32'hFFFF_C0B3);
    lat = 4;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("wrap_pc", bus.PC, 32'd0);
    check("wrap_req", 32'(bus.imem_req), 32'd1);
    check("wrap_addr", bus.imem_addr, 32'd0);

    // reset while WAIT with a response still in flight
    bus.instr_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    rv0 = rvcnt;
    check("rw_pc", bus.PC, 32'h100);
    check("rw_req", 32'(bus.imem_req), 32'd0);
    check("rw_instret", bus.instret, 32'd0);
    n = 0;
    seen = 1'b0;
    while (!bus.imem_req && n < 12) begin
      @(negedge clk);
      n++;
      if (bus.instr_valid) seen = 1'b1;
    end
    check("rw_req_tmo", 32'(bus.imem_req), 32'd1);
    check("rw_delay", 32'(n), 32'd3);
    check("rw_addr", bus.imem_addr, 32'h100);
    check("rw_dropped", 32'(rvcnt - rv0), 32'd1);
    check("rw_novalid", 32'(seen), 32'd0);
    wait_valid(20, n);
    check("lat4_valid", 32'(n), 32'd5);
    check("rw_instr", bus.Instr, 32'h40B5_0533);
    check("rw_pc2", bus.PC, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
